// File: rtl/button_pkg.sv
// Shared types and constants for push-button conditioning logic.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam logic        BTN_RELEASED        = 1'b0;

endpackage

// File: rtl/input_synchronizer.sv
// Multi-flop synchroniser for asynchronous board inputs, synchronous reset.
module input_synchronizer
    import button_pkg::*;
#(
    parameter int unsigned STAGES    = DEFAULT_SYNC_STAGES,
    parameter logic        RESET_VAL = BTN_RELEASED
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], din};
        end
    end

    assign dout = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Push-button synchroniser, debouncer and press/release/count-up pulse generator.
// Optional auto-repeat while held: define BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 500000,
    parameter int unsigned SYNC_STAGES         = DEFAULT_SYNC_STAGES,
    parameter bit          ACTIVE_LOW          = 1'b0,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_button,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || SYNC_STAGES < 2 || REPEAT_DELAY_CYCLES < 2 ||
        REPEAT_RATE_CYCLES < 1 || REPEAT_RATE_CYCLES > REPEAT_DELAY_CYCLES) begin : g_bad_params
        $error("button_debouncer: illegal parameter combination");
    end

    logic sync_out;

    input_synchronizer #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (BTN_RELEASED)
    ) u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (i_button ^ ACTIVE_LOW),
        .dout (sync_out)
    );

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
    logic             level_d, press_d, release_d;
    logic             rpt_strobe_c;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            stab_cnt_q <= '0;
            o_level    <= 1'b0;
            o_press    <= 1'b0;
            o_release  <= 1'b0;
            o_pulse    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_cnt_q <= stab_cnt_d;
            o_level    <= level_d;
            o_press    <= press_d;
            o_release  <= release_d;
            o_pulse    <= press_d | rpt_strobe_c;
        end
    end

    // Stability counter runs while the synchronised pin disagrees with the accepted level.
    always_comb begin
        state_d    = state_q;
        level_d    = o_level;
        press_d    = 1'b0;
        release_d  = 1'b0;
        stab_cnt_d = '0;
        if (sync_out != o_level) begin
            stab_cnt_d = (stab_cnt_q == CNT_MAX) ? stab_cnt_q : stab_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (sync_out) begin
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!sync_out) begin
                    state_d = IDLE;
                end else if (stab_cnt_q == CNT_MAX) begin
                    state_d    = HELD;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    stab_cnt_d = '0;
                end
            end
            HELD: begin
                if (!sync_out) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (sync_out) begin
                    state_d = HELD;
                end else if (stab_cnt_q == CNT_MAX) begin
                    state_d    = IDLE;
                    level_d    = 1'b0;
                    release_d  = 1'b1;
                    stab_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY_CYCLES);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_first_q, rpt_first_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end

    // Counter is zero on the press cycle, so a strobe can never coincide with o_press.
    always_comb begin
        rpt_cnt_d    = '0;
        rpt_first_d  = 1'b1;
        rpt_strobe_c = 1'b0;
        if ((state_q == HELD || state_q == RELEASE_WAIT) && state_d != IDLE) begin
            rpt_first_d = rpt_first_q;
            if (rpt_cnt_q == (rpt_first_q ? RPT_FIRST : RPT_NEXT)) begin
                rpt_strobe_c = 1'b1;
                rpt_first_d  = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
        end
    end
`else
    assign rpt_strobe_c = 1'b0;
`endif

endmodule
